// File: rtl/alu_issue_decode_if.sv
// Instruction-in / operand-bundle-out / writeback signal group for alu_issue_decode.
// The slave modport is the decoder's view; master is the driver/ALU-side view.
interface alu_issue_decode_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] Iimm;
    logic        isALUreg;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        illegal;

    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  instr_valid,
        input  instr,
        input  out_ready,
        input  wb_en,
        input  wb_rd,
        input  wb_data,
        output instr_ready,
        output out_valid,
        output rs1,
        output rs2,
        output Iimm,
        output isALUreg,
        output funct3,
        output funct7,
        output rd,
        output illegal
    );

    modport master (
        output instr_valid,
        output instr,
        output out_ready,
        output wb_en,
        output wb_rd,
        output wb_data,
        input  instr_ready,
        input  out_valid,
        input  rs1,
        input  rs2,
        input  Iimm,
        input  isALUreg,
        input  funct3,
        input  funct7,
        input  rd,
        input  illegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// RV32I OP/OP-IMM issue stage: decodes, reads the 32x32 register file with writeback
// forwarding, and presents a registered operand bundle to the ALU over valid/ready.
module alu_issue_decode #(
    parameter bit RESET_REGFILE = 1'b1
) (
    input logic               clk,
    input logic               rst,
    alu_issue_decode_if.slave io_bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [31:0] r_regs [32];

    logic        r_out_valid;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_iimm;
    logic        r_is_alu_reg;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rd;
    logic        r_illegal;
    logic [4:0]  r_rs1_idx;
    logic [4:0]  r_rs2_idx;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd_idx;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [6:0]  w_funct7_raw;
    logic        w_is_op;
    logic        w_is_op_imm;
    logic        w_is_shift_imm;
    logic        w_illegal;
    logic [6:0]  w_funct7;
    logic [31:0] w_iimm;
    logic        w_accept;
    logic        w_hold;
    logic        w_wb_we;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [4:0]  w_rs2_idx_kept;

    // Field extraction
    assign w_opcode     = io_bus.instr[6:0];
    assign w_rd_idx     = io_bus.instr[11:7];
    assign w_funct3     = io_bus.instr[14:12];
    assign w_rs1_idx    = io_bus.instr[19:15];
    assign w_rs2_idx    = io_bus.instr[24:20];
    assign w_funct7_raw = io_bus.instr[31:25];
    assign w_iimm       = {{20{io_bus.instr[31]}}, io_bus.instr[31:20]};

    assign w_is_op        = (w_opcode == OPC_OP);
    assign w_is_op_imm    = (w_opcode == OPC_OP_IMM);
    assign w_is_shift_imm = w_is_op_imm && (w_funct3 == 3'b001 || w_funct3 == 3'b101);

    // Only shift immediates carry a real funct7; a negative addi must not look like sub.
    assign w_funct7 = (w_is_op || w_is_shift_imm) ? w_funct7_raw : 7'b0;

    always_comb begin
        w_illegal = 1'b0;
        if (w_is_op) begin
            if (w_funct7_raw == F7_ALT) begin
                w_illegal = !(w_funct3 == 3'b000 || w_funct3 == 3'b101);
            end else if (w_funct7_raw != F7_BASE) begin
                w_illegal = 1'b1;
            end
        end else if (w_is_op_imm) begin
            if (w_funct3 == 3'b001) begin
                w_illegal = (w_funct7_raw != F7_BASE);
            end else if (w_funct3 == 3'b101) begin
                w_illegal = !(w_funct7_raw == F7_BASE || w_funct7_raw == F7_ALT);
            end
        end else begin
            w_illegal = 1'b1;
        end
    end

    // Handshake
    assign io_bus.instr_ready = !r_out_valid || io_bus.out_ready;
    assign w_accept           = io_bus.instr_valid && io_bus.instr_ready;
    assign w_hold             = r_out_valid && !io_bus.out_ready;
    assign w_wb_we            = io_bus.wb_en && (io_bus.wb_rd != 5'd0);

    // Register-file read with same-cycle writeback forwarding
    always_comb begin
        w_rs1_val = 32'd0;
        if (w_rs1_idx != 5'd0) begin
            if (w_wb_we && io_bus.wb_rd == w_rs1_idx) begin
                w_rs1_val = io_bus.wb_data;
            end else begin
                w_rs1_val = r_regs[w_rs1_idx];
            end
        end
    end

    always_comb begin
        w_rs2_val = 32'd0;
        if (w_is_op && w_rs2_idx != 5'd0) begin
            if (w_wb_we && io_bus.wb_rd == w_rs2_idx) begin
                w_rs2_val = io_bus.wb_data;
            end else begin
                w_rs2_val = r_regs[w_rs2_idx];
            end
        end
    end

    // A zero index never matches a write, so non-OP bundles never get rs2 refreshed.
    assign w_rs2_idx_kept = w_is_op ? w_rs2_idx : 5'd0;

    // Register file
    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESET_REGFILE) begin
                for (int i = 0; i < 32; i++) begin
                    r_regs[i] <= 32'd0;
                end
            end
        end else if (w_wb_we) begin
            r_regs[io_bus.wb_rd] <= io_bus.wb_data;
        end
    end

    // Output bundle stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
            r_iimm       <= 32'd0;
            r_is_alu_reg <= 1'b0;
            r_funct3     <= 3'd0;
            r_funct7     <= 7'd0;
            r_rd         <= 5'd0;
            r_illegal    <= 1'b0;
            r_rs1_idx    <= 5'd0;
            r_rs2_idx    <= 5'd0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_rs1        <= w_rs1_val;
            r_rs2        <= w_rs2_val;
            r_iimm       <= w_iimm;
            r_is_alu_reg <= w_is_op;
            r_funct3     <= w_funct3;
            r_funct7     <= w_funct7;
            r_rd         <= w_illegal ? 5'd0 : w_rd_idx;
            r_illegal    <= w_illegal;
            r_rs1_idx    <= w_rs1_idx;
            r_rs2_idx    <= w_rs2_idx_kept;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else if (w_hold && w_wb_we) begin
            // Keep a stalled bundle coherent with writes that land while it waits.
            if (io_bus.wb_rd == r_rs1_idx) begin
                r_rs1 <= io_bus.wb_data;
            end
            if (io_bus.wb_rd == r_rs2_idx) begin
                r_rs2 <= io_bus.wb_data;
            end
        end
    end

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.rs1       = r_rs1;
    assign io_bus.rs2       = r_rs2;
    assign io_bus.Iimm      = r_iimm;
    assign io_bus.isALUreg  = r_is_alu_reg;
    assign io_bus.funct3    = r_funct3;
    assign io_bus.funct7    = r_funct7;
    assign io_bus.rd        = r_rd;
    assign io_bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed bench for alu_issue_decode: decode fields, handshake stalls, forwarding,
// held-bundle refresh, illegal encodings and reset behaviour.
module tb_alu_issue_decode;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    alu_issue_decode_if bus ();

    alu_issue_decode #(
        .RESET_REGFILE(1'b1)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] idx, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = idx;
        bus.wb_data = data;
        step();
        bus.wb_en   = 1'b0;
    endtask

    logic [31:0] illegal_vec [4];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        illegal_vec[0] = 32'h40111093;  // slli with funct7=0100000
        illegal_vec[1] = 32'h00002083;  // lw
        illegal_vec[2] = 32'h023100B3;  // OP funct7=0000001
        illegal_vec[3] = 32'h40629633;  // OP funct7=0100000, funct3=001

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.out_ready   = 1'b0;
        bus.wb_en       = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.wb_data     = 32'd0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_illegal", bus.illegal, 0);
        check_eq("rst_rs1", bus.rs1, 0);
        check_eq("rst_rs2", bus.rs2, 0);
        check_eq("rst_iimm", bus.Iimm, 0);
        check_eq("rst_funct7", bus.funct7, 0);
        check_eq("rst_rd", bus.rd, 0);
        check_eq("rst_isalureg", bus.isALUreg, 0);
        check_eq("rst_instr_ready", bus.instr_ready, 1);

        wb(5'd5, 32'h0000_0010);
        wb(5'd6, 32'h0000_0003);
        wb(5'd31, 32'hAAAA_5555);

        // sub x7,x5,x6
        bus.instr       = 32'h406283B3;
        bus.instr_valid = 1'b1;
        bus.out_ready   = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        check_eq("sub_valid", bus.out_valid, 1);
        check_eq("sub_rs1", bus.rs1, 32'h10);
        check_eq("sub_rs2", bus.rs2, 32'h3);
        check_eq("sub_funct3", bus.funct3, 0);
        check_eq("sub_funct7", bus.funct7, 7'b0100000);
        check_eq("sub_isalureg", bus.isALUreg, 1);
        check_eq("sub_rd", bus.rd, 7);
        check_eq("sub_illegal", bus.illegal, 0);
        check_eq("sub_iimm", bus.Iimm, 32'h406);
        step();
        check_eq("drain_valid", bus.out_valid, 0);

        // addi x1,x0,-1 (rs2 field = 31, which holds a nonzero value)
        bus.instr       = 32'hFFF00093;
        bus.instr_valid = 1'b1;
        step();
        bus.out_ready   = 1'b0;
        check_eq("addi_iimm", bus.Iimm, 32'hFFFF_FFFF);
        check_eq("addi_funct7", bus.funct7, 0);
        check_eq("addi_isalureg", bus.isALUreg, 0);
        check_eq("addi_rs1", bus.rs1, 0);
        check_eq("addi_rs2", bus.rs2, 0);
        check_eq("addi_rd", bus.rd, 1);

        // Stall for 3 cycles with add x8,x5,x6 pending
        bus.instr = 32'h00628433;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("stall_instr_ready", bus.instr_ready, 0);
            step();
            check_eq("stall_valid", bus.out_valid, 1);
            check_eq("stall_rd", bus.rd, 1);
            check_eq("stall_iimm", bus.Iimm, 32'hFFFF_FFFF);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("release_instr_ready", bus.instr_ready, 1);
        step();
        check_eq("add_valid", bus.out_valid, 1);
        check_eq("add_rd", bus.rd, 8);
        check_eq("add_rs1", bus.rs1, 32'h10);
        check_eq("add_rs2", bus.rs2, 32'h3);
        check_eq("add_funct7", bus.funct7, 0);
        bus.instr = 32'h0062E4B3;  // or x9,x5,x6
        step();
        check_eq("or_valid", bus.out_valid, 1);
        check_eq("or_rd", bus.rd, 9);
        check_eq("or_funct3", bus.funct3, 3'b110);
        bus.instr = 32'h40335593;  // srai x11,x6,3
        step();
        bus.instr_valid = 1'b0;
        check_eq("srai_rd", bus.rd, 11);
        check_eq("srai_funct3", bus.funct3, 3'b101);
        check_eq("srai_funct7", bus.funct7, 7'b0100000);
        check_eq("srai_rs1", bus.rs1, 32'h3);
        check_eq("srai_rs2", bus.rs2, 0);
        check_eq("srai_iimm", bus.Iimm, 32'h403);
        check_eq("srai_illegal", bus.illegal, 0);
        step();
        check_eq("srai_drain", bus.out_valid, 0);

        // add x3,x2,x2 with same-cycle write of x2
        bus.instr       = 32'h002101B3;
        bus.instr_valid = 1'b1;
        bus.wb_en       = 1'b1;
        bus.wb_rd       = 5'd2;
        bus.wb_data     = 32'hDEAD_BEEF;
        step();
        bus.instr_valid = 1'b0;
        bus.wb_en       = 1'b0;
        bus.out_ready   = 1'b0;
        check_eq("fwd_rs1", bus.rs1, 32'hDEAD_BEEF);
        check_eq("fwd_rs2", bus.rs2, 32'hDEAD_BEEF);
        check_eq("fwd_rd", bus.rd, 3);
        wb(5'd2, 32'h0000_1234);
        check_eq("refresh_rs1", bus.rs1, 32'h1234);
        check_eq("refresh_rs2", bus.rs2, 32'h1234);
        wb(5'd3, 32'h0000_7777);
        check_eq("other_wr_rs1", bus.rs1, 32'h1234);
        wb(5'd0, 32'h0000_5555);
        check_eq("x0_wr_rs1", bus.rs1, 32'h1234);
        check_eq("x0_wr_valid", bus.out_valid, 1);

        // add x4,x0,x2 with simultaneous write to x0
        bus.out_ready   = 1'b1;
        bus.instr       = 32'h00200233;
        bus.instr_valid = 1'b1;
        bus.wb_en       = 1'b1;
        bus.wb_rd       = 5'd0;
        bus.wb_data     = 32'h0000_5555;
        step();
        bus.wb_en = 1'b0;
        check_eq("x0_read_rs1", bus.rs1, 0);
        check_eq("x0_read_rs2", bus.rs2, 32'h1234);
        check_eq("x0_read_rd", bus.rd, 4);

        // Illegal encodings back to back
        for (int k = 0; k < 4; k++) begin
            bus.instr = illegal_vec[k];
            step();
            check_eq($sformatf("ill%0d_illegal", k), bus.illegal, 1);
            check_eq($sformatf("ill%0d_rd", k), bus.rd, 0);
            check_eq($sformatf("ill%0d_valid", k), bus.out_valid, 1);
        end
        bus.instr = 32'h4062D633;  // sra x12,x5,x6
        step();
        check_eq("sra_illegal", bus.illegal, 0);
        check_eq("sra_rd", bus.rd, 12);
        check_eq("sra_funct7", bus.funct7, 7'b0100000);

        // Reset with a valid bundle and a pending accept
        bus.instr = 32'h00628433;
        step();
        check_eq("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        check_eq("mid_rst_valid", bus.out_valid, 0);
        check_eq("mid_rst_rs1", bus.rs1, 0);
        check_eq("mid_rst_rs2", bus.rs2, 0);
        check_eq("mid_rst_rd", bus.rd, 0);
        check_eq("mid_rst_iimm", bus.Iimm, 0);
        check_eq("mid_rst_funct3", bus.funct3, 0);
        check_eq("mid_rst_funct7", bus.funct7, 0);
        check_eq("mid_rst_isalureg", bus.isALUreg, 0);
        check_eq("mid_rst_illegal", bus.illegal, 0);
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        check_eq("post_rst_valid", bus.out_valid, 1);
        check_eq("post_rst_x5", bus.rs1, 0);
        check_eq("post_rst_x6", bus.rs2, 0);
        check_eq("post_rst_rd", bus.rd, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
